// File: rtl/timer_sched_pkg.sv
// Shared constants, register map and state encoding for the timer scheduler.
// Optional feature macro: TIMER_SCHED_ABORT_EN (adds the WR_STOP state).
package timer_sched_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;

    localparam int CTL_ITO_BIT   = 0;
    localparam int CTL_CONT_BIT  = 1;
    localparam int CTL_START_BIT = 2;
    localparam int CTL_STOP_BIT  = 3;

    // One-shot start: interrupt enabled, continuous mode off.
    localparam logic [15:0] CTL_START_VAL =
        16'((1 << CTL_ITO_BIT) | (0 << CTL_CONT_BIT) | (1 << CTL_START_BIT));
    localparam logic [15:0] CTL_STOP_VAL  = 16'(1 << CTL_STOP_BIT);
    localparam logic [15:0] STAT_CLR_VAL  = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTL,
        WAIT_IRQ,
        WR_STAT,
        DONE
`ifdef TIMER_SCHED_ABORT_EN
        , WR_STOP
`endif
    } state_t;

endpackage

// File: rtl/nios_timer_sched_if.sv
// Avalon-MM write port towards the interval timer plus its interrupt line.
// Master side is the scheduler, slave side the timer.
interface nios_timer_sched_if;

    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic        timer_irq;

    modport master (
        output av_address,
        output av_chipselect,
        output av_write_n,
        output av_writedata,
        input  timer_irq
    );

    modport slave (
        input  av_address,
        input  av_chipselect,
        input  av_write_n,
        input  av_writedata,
        output timer_irq
    );

endinterface

// File: rtl/timer_sched_rr_arb.sv
// Round-robin picker: searches from (last + 1) mod NUM_REQ upward.
// Purely combinational; the caller latches the winner.
module timer_sched_rr_arb
    import timer_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic               valid,
    output logic [IW-1:0]      grant
);

    logic [IW-1:0] w_idx;

    // First requesting index after the previous winner wins
    always_comb begin
        valid = 1'b0;
        grant = last;
        w_idx = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IW'((int'(last) + k) % NUM_REQ);
            if (!valid && req[w_idx]) begin
                valid = 1'b1;
                grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/nios_timer_sched.sv
// Shares one Nios interval timer among NUM_REQ requesters, one-shot each.
// Optional macro TIMER_SCHED_ABORT_EN adds per-requester abort while waiting.
module nios_timer_sched
    import timer_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  period_i,
`ifdef TIMER_SCHED_ABORT_EN
    input  logic [NUM_REQ-1:0]     abort,
`endif
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [IW-1:0]          grant_id,
    nios_timer_sched_if.master     av
);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_gid;
    logic [31:0]   r_period;
    logic [31:0]   w_period;
    logic          w_valid;
    logic [IW-1:0] w_grant;
`ifdef TIMER_SCHED_ABORT_EN
    logic          r_aborted;
`endif

    timer_sched_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req),
        .last  (r_gid),
        .valid (w_valid),
        .grant (w_grant)
    );

    // Select the winning requester's period slice
    always_comb begin
        w_period = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == IW'(i)) w_period = period_i[32*i +: 32];
        end
    end

    // State register; grant and period captured on the grant edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_gid    <= IW'(NUM_REQ - 1);
            r_period <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_valid) begin
                r_gid    <= w_grant;
                r_period <= w_period;
            end
        end
    end

`ifdef TIMER_SCHED_ABORT_EN
    // Remember an aborted run so the status clear returns straight to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                r_aborted <= 1'b0;
        else if (w_next == WR_STOP) r_aborted <= 1'b1;
        else if (r_state == IDLE)   r_aborted <= 1'b0;
    end
`endif

    // Next-state and one-cycle Avalon writes decoded from the current state
    always_comb begin
        w_next           = r_state;
        av.av_chipselect = 1'b0;
        av.av_write_n    = 1'b1;
        av.av_address    = REG_STATUS;
        av.av_writedata  = '0;
        unique case (r_state)
            IDLE: begin
                if (w_valid) w_next = WR_PL;
            end
            WR_PL: begin
                av.av_chipselect = 1'b1;
                av.av_write_n    = 1'b0;
                av.av_address    = REG_PERIODL;
                av.av_writedata  = r_period[15:0];
                w_next           = WR_PH;
            end
            WR_PH: begin
                av.av_chipselect = 1'b1;
                av.av_write_n    = 1'b0;
                av.av_address    = REG_PERIODH;
                av.av_writedata  = r_period[31:16];
                w_next           = WR_CTL;
            end
            WR_CTL: begin
                av.av_chipselect = 1'b1;
                av.av_write_n    = 1'b0;
                av.av_address    = REG_CONTROL;
                av.av_writedata  = CTL_START_VAL;
                w_next           = WAIT_IRQ;
            end
            WAIT_IRQ: begin
`ifdef TIMER_SCHED_ABORT_EN
                if (abort[r_gid])      w_next = WR_STOP;
                else if (av.timer_irq) w_next = WR_STAT;
`else
                if (av.timer_irq) w_next = WR_STAT;
`endif
            end
            WR_STAT: begin
                av.av_chipselect = 1'b1;
                av.av_write_n    = 1'b0;
                av.av_address    = REG_STATUS;
                av.av_writedata  = STAT_CLR_VAL;
`ifdef TIMER_SCHED_ABORT_EN
                w_next           = r_aborted ? IDLE : DONE;
`else
                w_next           = DONE;
`endif
            end
            DONE: begin
                w_next = IDLE;
            end
`ifdef TIMER_SCHED_ABORT_EN
            WR_STOP: begin
                av.av_chipselect = 1'b1;
                av.av_write_n    = 1'b0;
                av.av_address    = REG_CONTROL;
                av.av_writedata  = CTL_STOP_VAL;
                w_next           = WR_STAT;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    // Completion pulse goes only to the requester that owns the timer
    always_comb begin
        done = '0;
        if (r_state == DONE) done[r_gid] = 1'b1;
    end

    assign busy     = (r_state != IDLE);
    assign grant_id = r_gid;

endmodule

// File: tb/tb_nios_timer_sched.sv
// Directed bench for nios_timer_sched with a write/done scoreboard.
// Abort scenario is compiled in only with TIMER_SCHED_ABORT_EN.
module tb_nios_timer_sched;
    import timer_sched_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [32*N-1:0] period_i;
    logic [N-1:0]    done;
    logic            busy;
    logic [1:0]      grant_id;
`ifdef TIMER_SCHED_ABORT_EN
    logic [N-1:0]    abort;
`endif

    nios_timer_sched_if intf();

    nios_timer_sched #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .period_i (period_i),
`ifdef TIMER_SCHED_ABORT_EN
        .abort    (abort),
`endif
        .done     (done),
        .busy     (busy),
        .grant_id (grant_id),
        .av       (intf.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    wr_t mon_e;
    int  mon_id;
    int  n_assert = 0;
    int  n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every bus write must match the next expected write, in order
    always @(negedge clk) begin
        if (intf.av_chipselect === 1'b1) begin
            chk("write_n", 32'(intf.av_write_n), 32'h0);
            if (exp_wr.size() == 0) begin
                chk("extra_write",
                    {13'h0, intf.av_address, intf.av_writedata},
                    32'hDEAD_0000);
            end else begin
                mon_e = exp_wr.pop_front();
                chk("wr_addr", 32'(intf.av_address), 32'(mon_e.a));
                chk("wr_data", 32'(intf.av_writedata), 32'(mon_e.d));
            end
        end else begin
            chk("idle_bus", {15'h0, intf.av_write_n, intf.av_writedata},
                32'h0001_0000);
        end
    end

    // Every done pulse must match the next expected completion
    always @(negedge clk) begin
        if (done !== '0) begin
            if (exp_done.size() == 0) begin
                chk("extra_done", 32'(done), 32'h0);
            end else begin
                mon_id = exp_done.pop_front();
                chk("done_vec", 32'(done), 32'(1 << mon_id));
            end
        end
    end

    task automatic set_per(input int id, input logic [31:0] p);
        period_i[id*32 +: 32] = p;
    endtask

    task automatic push_start(input logic [31:0] p);
        exp_wr.push_back(wr_t'{REG_PERIODL, p[15:0]});
        exp_wr.push_back(wr_t'{REG_PERIODH, p[31:16]});
        exp_wr.push_back(wr_t'{REG_CONTROL, 16'h0005});
    endtask

    // Requests must already be driven; called #1 after an edge in IDLE
    task automatic serve(input int id, input logic [31:0] p,
                         input int dly, input int pulse_id,
                         input bit drop_all);
        push_start(p);
        exp_wr.push_back(wr_t'{REG_STATUS, 16'h0000});
        exp_done.push_back(id);
        @(posedge clk); #1;
        chk("grant_id", 32'(grant_id), 32'(id));
        chk("busy_on_grant", 32'(busy), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("wait_cs", 32'(intf.av_chipselect), 32'h0);
        chk("wait_busy", 32'(busy), 32'h1);
        if (pulse_id >= 0) begin
            req[pulse_id] = 1'b1;
            @(posedge clk); #1;
            req[pulse_id] = 1'b0;
        end
        repeat (dly) begin
            @(posedge clk); #1;
        end
        intf.timer_irq = 1'b1;
        @(posedge clk); #1;
        intf.timer_irq = 1'b0;
        chk("done_early", 32'(done), 32'h0);
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 32'(1 << id));
        if (drop_all) req = '0;
        else          req[id] = req[id];
        @(posedge clk); #1;
        chk("done_cleared", 32'(done), 32'h0);
        chk("busy_idle", 32'(busy), 32'h0);
    endtask

    initial begin
        reset          = 1'b1;
        req            = '0;
        period_i       = '0;
        intf.timer_irq = 1'b0;
`ifdef TIMER_SCHED_ABORT_EN
        abort          = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h3);
        chk("rst_cs", 32'(intf.av_chipselect), 32'h0);
        chk("rst_wn", 32'(intf.av_write_n), 32'h1);
        chk("rst_addr", 32'(intf.av_address), 32'h0);
        chk("rst_data", 32'(intf.av_writedata), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // fairness: all four held, grants 0,1,2,3,0
        for (int i = 0; i < N; i++) set_per(i, 32'h0001_0010 * (i + 1));
        req = 4'b1111;
        serve(0, 32'h0001_0010, 2, -1, 1'b0);
        serve(1, 32'h0002_0020, 1, -1, 1'b0);
        serve(2, 32'h0003_0030, 3, -1, 1'b0);
        serve(3, 32'h0004_0040, 0, -1, 1'b0);
        serve(0, 32'h0001_0010, 1, -1, 1'b1);

        // single requester with a large period (irq scaled down)
        set_per(0, 32'h0001_86A0);
        req[0] = 1'b1;
        serve(0, 32'h0001_86A0, 30, -1, 1'b1);

        // zero period passes through untouched
        set_per(3, 32'h0000_0000);
        req[3] = 1'b1;
        serve(3, 32'h0000_0000, 0, -1, 1'b1);

        // requester 2 pulses while 1 is served and withdraws
        set_per(1, 32'h0000_1234);
        set_per(2, 32'hABCD_EF01);
        req[1] = 1'b1;
        serve(1, 32'h0000_1234, 2, 2, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("withdraw_busy", 32'(busy), 32'h0);
        chk("withdraw_gid", 32'(grant_id), 32'h1);

        // reset while waiting on the timer abandons the run
        set_per(2, 32'h0000_0777);
        req[2] = 1'b1;
        push_start(32'h0000_0777);
        @(posedge clk); #1;
        chk("pre_rst_gid", 32'(grant_id), 32'h2);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        req   = '0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_cs", 32'(intf.av_chipselect), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_gid", 32'(grant_id), 32'h3);
        reset = 1'b0;
        @(posedge clk); #1;
        set_per(1, 32'h0005_0006);
        req[1] = 1'b1;
        serve(1, 32'h0005_0006, 1, -1, 1'b1);

`ifdef TIMER_SCHED_ABORT_EN
        // abort while waiting: stop, clear status, no done
        set_per(3, 32'h0000_0100);
        req[3] = 1'b1;
        push_start(32'h0000_0100);
        exp_wr.push_back(wr_t'{REG_CONTROL, 16'h0008});
        exp_wr.push_back(wr_t'{REG_STATUS, 16'h0000});
        @(posedge clk); #1;
        chk("abort_gid", 32'(grant_id), 32'h3);
        repeat (3) @(posedge clk);
        #1;
        abort[3] = 1'b1;
        @(posedge clk); #1;
        abort = '0;
        req   = '0;
        chk("abort_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        chk("abort_done_a", 32'(done), 32'h0);
        @(posedge clk); #1;
        chk("abort_idle", 32'(busy), 32'h0);
        chk("abort_done_b", 32'(done), 32'h0);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'h0);
        chk("done_queue_empty", 32'(exp_done.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_timer_sched.md
NIOS_TIMER_SCHED -- requirements
Module: nios_timer_sched

Interface
REQ-001 SHALL have parameter: NUM_REQ, 4, number of requesters (2..8).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req  input  NUM_REQ  per-requester level request; held until its done pulse.
REQ-005 SHALL have port: period_i  input  32*NUM_REQ  per-requester delay value; slice i = bits [32i+31:32i]; stable while req[i] is high.
REQ-006 SHALL have port: done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-007 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-008 SHALL have port: grant_id  output  clog2(NUM_REQ)  index of the current or last granted requester.
REQ-009 SHALL have ports to the interval-timer slave: av_address out 3, av_chipselect out 1, av_write_n out 1, av_writedata out 16, timer_irq in 1.

Function
REQ-010 Timer register map SHALL be: 0 status (any write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h.
REQ-011 FSM states SHALL be: IDLE, WR_PL, WR_PH, WR_CTL, WAIT_IRQ, WR_STAT, DONE; one-cycle Avalon write per WR_* state; no waitrequest.
REQ-012 IDLE: if any req bit is high, grant SHALL use round-robin starting at (last grant + 1) mod NUM_REQ; latch grant_id and period; go to WR_PL next cycle.
REQ-013 WR_PL SHALL drive addr 2, data period[15:0]; WR_PH addr 3, data period[31:16]; WR_CTL addr 1, data 0x0005 (ITO|START, CONT=0).
REQ-014 WAIT_IRQ SHALL hold av_chipselect=0 until timer_irq=1; then WR_STAT SHALL write addr 0, data 0x0000; then DONE.
REQ-015 DONE SHALL pulse done[grant_id] for exactly one cycle and return to IDLE; requester drops req on that edge; req still high in IDLE is a new request.
REQ-016 Request-to-timer-start latency SHALL be 4 cycles (grant edge + 3 writes); irq-to-done latency SHALL be 2 cycles.
REQ-017 req[i] deasserted before grant SHALL withdraw it with no bus activity; deasserted after grant SHALL NOT abort the sequence (done still pulses).
REQ-018 In non-write states av_chipselect=0, av_write_n=1, av_writedata=0.
REQ-019 period value 0 SHALL be passed unchanged (timer expires immediately); no arithmetic on period.

Reset
REQ-020 On reset: state IDLE, done=0, busy=0, grant_id=NUM_REQ-1 (so first grant starts at 0), av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0.
REQ-021 Reset mid-sequence SHALL abandon the sequence without any further bus write; no done pulse.

Configuration
REQ-022 Macro TIMER_SCHED_ABORT_EN: when defined, add input abort (NUM_REQ); abort[grant_id] in WAIT_IRQ SHALL go to WR_STOP (addr 1, data 0x0008), then WR_STAT, then IDLE, with no done pulse; abort in other states ignored.
REQ-023 Without TIMER_SCHED_ABORT_EN: no abort port, no WR_STOP state; behaviour per REQ-011..019.

Structure
REQ-024 Package timer_sched_pkg SHALL hold register address constants, control bit positions, CTL_START_VAL=0x0005, CTL_STOP_VAL=0x0008 and the state enum.
REQ-025 Round-robin selection SHALL be sub-module timer_sched_rr_arb (req, last grant in; valid, grant index out).

Verification
REQ-026 Single: req[0]=1, period 0x0001_86A0 -> writes (2,0x86A0),(3,0x0001),(1,0x0005); irq after 100001 cycles -> write (0,0x0000), done[0] pulse 2 cycles after irq.
REQ-027 Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0; each done exactly once per round.
REQ-028 Withdraw: req[2] high 1 cycle while busy serving 1, then low -> no grant to 2, no bus writes for 2.
REQ-029 Reset: assert reset in WAIT_IRQ -> next cycle busy=0, chipselect=0, no done; after release req[1] -> first grant 1's sequence.
REQ-030 Abort (macro on): req[3], abort[3] in WAIT_IRQ -> writes (1,0x0008),(0,0x0000), busy=0, done stays 0.
REQ-031 Zero period: period 0 -> writes (2,0),(3,0),(1,0x0005); done after irq.
